stream_fifo_buffer: RTL

Parametrised successor to the single-register stream output stage. It is a DEPTH-entry first-word-fall-through buffer with registered outputs and a registered in_ready, so no combinational path runs from out_ready to in_ready. It sits between stream producers and consumers where timing closure or short stall absorption is needed. It also exposes the current fill level for flow-control and monitoring logic.

---
 rtl/stream_fifo_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stream_fifo_buffer.sv
// stream_fifo_buffer
//   DEPTH-entry first-word-fall-through stream buffer with registered outputs.
//   in_ready is registered, so no combinational path runs from out_ready to in_ready.
//   The fill level is exposed on count.
//
// Parameters
//   DATA_WIDTH : payload width in bits
//   DEPTH      : total capacity in words, including the output register
//                (power of two, >= 2)
//
// Ports
//   aclk       : clock, rising edge
//   aresetn    : synchronous active-low reset
//   in_data    : upstream payload
//   in_valid   : upstream valid
//   in_ready   : registered, high while at least one slot is free
//   out_data   : registered head-of-queue payload
//   out_valid  : registered head-of-queue valid
//   out_ready  : downstream ready
//   count      : registered number of words held, 0..DEPTH
//
// Optional feature (macro STREAM_FIFO_BUFFER_LAST_EN)
//   in_last / out_last : a frame-end flag stored alongside each word.
//   The flag travels with the same latency and ordering as the payload.

module stream_fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
`ifdef STREAM_FIFO_BUFFER_LAST_EN
    input  logic                         in_last,
    output logic                         out_last,
`endif
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
`ifdef STREAM_FIFO_BUFFER_LAST_EN
    localparam int unsigned WW = DATA_WIDTH + 1;
`else
    localparam int unsigned WW = DATA_WIDTH;
`endif

    logic [WW-1:0] in_word;
    logic [WW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] out_word_q, out_word_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic          accept;
    logic          pop;

`ifdef STREAM_FIFO_BUFFER_LAST_EN
    assign in_word = {in_last, in_data};
`else
    assign in_word = in_data;
`endif

    always_comb begin
        accept      = in_valid & in_ready_q;
        pop         = out_valid_q & out_ready;
        wptr_d      = wptr_q + PW'(accept);
        rptr_d      = rptr_q + PW'(pop);
        count_d     = count_q + CW'(accept) - CW'(pop);
        in_ready_d  = (count_d < CW'(DEPTH));
        out_valid_d = (count_d != '0);
        out_word_d  = out_word_q;
        if (count_d != '0) begin
            // The ring keeps every held word, including the one mirrored in the
            // output register. When nothing remains after the pop, the head for
            // the next cycle is the word arriving on this edge, taken straight
            // from the input because the ring write lands on the same edge.
            if (count_q == CW'(pop)) begin
                out_word_d = in_word;
            end else begin
                out_word_d = mem_q[rptr_d];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Storage has no reset; its contents are only meaningful between the pointers.
    always_ff @(posedge aclk) begin
        if (aresetn && accept) begin
            mem_q[wptr_q] <= in_word;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_word_q[DATA_WIDTH-1:0];
    assign count     = count_q;
`ifdef STREAM_FIFO_BUFFER_LAST_EN
    assign out_last  = out_word_q[DATA_WIDTH];
`endif

endmodule
